// File: rtl/dm_sba_mem_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_sba_mem_pkg
// Description : Shared types, constants and helpers for the SBA memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_sba_mem_pkg;

    // Width of the grant / response latency down-counters (latencies 0..15).
    localparam int unsigned LatCntW = 4;

    // Slave FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_WAIT  = 2'd1,
        RESP_WAIT = 2'd2
    } sba_mem_state_e;

    // A byte-enable pattern is legal when it is non-zero and its set bits
    // form a single contiguous run.
    function automatic logic be_legal(input logic [3:0] be);
        logic legal;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100,
            4'b0111, 4'b1110,
            4'b1111: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_sba_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_sba_mem_slave_if
// Description : req/gnt/r_valid bus between the SBA master and memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_sba_mem_slave_if;

    logic        slave_req_i;
    logic [31:0] slave_add_i;
    logic        slave_we_i;
    logic [31:0] slave_wdata_i;
    logic [3:0]  slave_be_i;
    logic        slave_gnt_o;
    logic        slave_r_valid_o;
    logic        slave_r_err_o;
    logic        slave_r_other_err_o;
    logic [31:0] slave_r_rdata_o;

    modport master (
        output slave_req_i, slave_add_i, slave_we_i, slave_wdata_i, slave_be_i,
        input  slave_gnt_o, slave_r_valid_o, slave_r_err_o, slave_r_other_err_o,
               slave_r_rdata_o
    );

    modport slave (
        input  slave_req_i, slave_add_i, slave_we_i, slave_wdata_i, slave_be_i,
        output slave_gnt_o, slave_r_valid_o, slave_r_err_o, slave_r_other_err_o,
               slave_r_rdata_o
    );

endinterface
`default_nettype wire

// File: rtl/dm_sba_mem_slave_array.sv
`default_nettype none
// ============================================================================
// Module      : dm_sba_mem_array
// Description : DEPTH x 32 single-port synchronous RAM with byte write enables
//               and a registered read port (BRAM-inferable, not reset).
// Revision    : 1.0 - initial release
// ============================================================================
module dm_sba_mem_array #(
    parameter int unsigned DEPTH = 256
) (
    input  wire logic                     clk_i,
    input  wire logic                     en_i,
    input  wire logic                     we_i,
    input  wire logic [3:0]               be_i,
    input  wire logic [$clog2(DEPTH)-1:0] idx_i,
    input  wire logic [31:0]              wdata_i,
    output logic [31:0]                   rdata_o
);

    logic [3:0][7:0] r_mem_q [DEPTH];
    logic [31:0]     r_rdata_q;

    // Byte-lane writes; the read register only updates on reads so it holds
    // the last read word across write accesses.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        r_mem_q[idx_i][b] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                r_rdata_q <= r_mem_q[idx_i];
            end
        end
    end

    assign rdata_o = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/dm_sba_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : dm_sba_mem_slave
// Description : SBA bus responder: programmable grant/response latency,
//               word-addressed scratch RAM, range / byte-enable / injected
//               error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_sba_mem_slave
    import dm_sba_mem_pkg::*;
#(
    parameter int unsigned DEPTH        = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned GNT_LATENCY  = 0,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    dm_sba_mem_slave_if.slave  bus,
    input  wire logic          inject_err_i,
    output logic               busy_o
);

    localparam int unsigned        c_IDX_W     = $clog2(DEPTH);
    localparam logic [32:0]        c_LIMIT     = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;
    localparam logic               c_GNT_COMB  = (GNT_LATENCY == 0);
    localparam logic [LatCntW-1:0] c_GNT_LOAD  = LatCntW'(GNT_LATENCY - 1);
    localparam logic [LatCntW-1:0] c_RESP_LOAD = LatCntW'(RESP_LATENCY - 1);

    sba_mem_state_e     r_state_q, w_state_d;
    logic [LatCntW-1:0] r_cnt_q, w_cnt_d;
    logic               r_gnt_q, w_gnt_d;
    logic               r_valid_q, w_valid_d;
    logic               r_err_q, w_err_d;
    logic               r_other_err_q, w_other_err_d;
    logic               r_rd_ok_q, w_rd_ok_d;
    logic               r_busy_q, w_busy_d;
    logic               r_pend_err_q, w_pend_err_d;
    logic               r_pend_oerr_q, w_pend_oerr_d;
    logic               r_pend_rd_q, w_pend_rd_d;

    logic               w_grant;
    logic [32:0]        w_add_ext;
    logic               w_range_err;
    logic               w_acc_err;
    logic               w_be_err;
    logic               w_rd_now;
    logic               w_mem_en;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_mem_rdata;

    // The grant cycle is the access commit point; with zero grant latency it
    // is a same-cycle echo of the request while idle.
    assign w_grant = (r_gnt_q || (c_GNT_COMB && (r_state_q == IDLE) && bus.slave_req_i))
                     && !rst_i;

    // Request decode: the range check uses the full address, index drops [1:0].
    assign w_add_ext   = {1'b0, bus.slave_add_i};
    assign w_range_err = (w_add_ext < {1'b0, BASE_ADDR}) || (w_add_ext >= c_LIMIT);
    assign w_acc_err   = w_range_err || inject_err_i;
    assign w_be_err    = !be_legal(bus.slave_be_i);
    assign w_rd_now    = !bus.slave_we_i && !w_acc_err && !w_be_err;
    assign w_mem_en    = w_grant && !w_acc_err && !w_be_err;
    assign w_idx       = c_IDX_W'((bus.slave_add_i - BASE_ADDR) >> 2);

    // State, counter and registered-output flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= '0;
            r_gnt_q       <= 1'b0;
            r_valid_q     <= 1'b0;
            r_err_q       <= 1'b0;
            r_other_err_q <= 1'b0;
            r_rd_ok_q     <= 1'b0;
            r_busy_q      <= 1'b0;
            r_pend_err_q  <= 1'b0;
            r_pend_oerr_q <= 1'b0;
            r_pend_rd_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_gnt_q       <= w_gnt_d;
            r_valid_q     <= w_valid_d;
            r_err_q       <= w_err_d;
            r_other_err_q <= w_other_err_d;
            r_rd_ok_q     <= w_rd_ok_d;
            r_busy_q      <= w_busy_d;
            r_pend_err_q  <= w_pend_err_d;
            r_pend_oerr_q <= w_pend_oerr_d;
            r_pend_rd_q   <= w_pend_rd_d;
        end
    end

    // Next state and latency counter.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            IDLE: begin
                if (w_grant) begin
                    w_state_d = RESP_WAIT;
                    w_cnt_d   = c_RESP_LOAD;
                end else if (!c_GNT_COMB && bus.slave_req_i) begin
                    w_state_d = GNT_WAIT;
                    w_cnt_d   = c_GNT_LOAD;
                end
            end
            GNT_WAIT: begin
                if (w_grant) begin
                    w_state_d = RESP_WAIT;
                    w_cnt_d   = c_RESP_LOAD;
                end else if (!bus.slave_req_i) begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - LatCntW'(1);
                end
            end
            RESP_WAIT: begin
                if (r_cnt_q == '0) begin
                    w_state_d = IDLE;
                end else begin
                    w_cnt_d = r_cnt_q - LatCntW'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Output decode: pulses are registered one cycle ahead from the next
    // state, and the access outcome is latched at grant until the response.
    always_comb begin
        w_gnt_d       = (w_state_d == GNT_WAIT) && (w_cnt_d == '0);
        w_valid_d     = (w_state_d == RESP_WAIT) && (w_cnt_d == '0);
        w_busy_d      = (w_state_d != IDLE);
        w_pend_err_d  = r_pend_err_q;
        w_pend_oerr_d = r_pend_oerr_q;
        w_pend_rd_d   = r_pend_rd_q;
        if (w_grant) begin
            w_pend_err_d  = w_acc_err;
            w_pend_oerr_d = w_be_err;
            w_pend_rd_d   = w_rd_now;
        end
        w_err_d       = w_valid_d && w_pend_err_d;
        w_other_err_d = w_valid_d && w_pend_oerr_d;
        w_rd_ok_d     = w_valid_d && w_pend_rd_d;
    end

    dm_sba_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (w_mem_en),
        .we_i    (bus.slave_we_i),
        .be_i    (bus.slave_be_i),
        .idx_i   (w_idx),
        .wdata_i (bus.slave_wdata_i),
        .rdata_o (w_mem_rdata)
    );

    assign bus.slave_gnt_o         = c_GNT_COMB ? w_grant : r_gnt_q;
    assign bus.slave_r_valid_o     = r_valid_q;
    assign bus.slave_r_err_o       = r_err_q;
    assign bus.slave_r_other_err_o = r_other_err_q;
    assign bus.slave_r_rdata_o     = r_rd_ok_q ? w_mem_rdata : 32'h0;
    assign busy_o                  = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_sba_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_sba_mem_slave
// Description : Self-checking bench: dut0 (default latencies) and dut1
//               (grant 2 / response 3) against a behavioural memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_sba_mem_slave;

    localparam logic [31:0] c_BASE  = 32'h0;
    localparam int          c_DEPTH = 256;

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        inj;
        logic        e;
        logic        oe;
        logic [31:0] rd;
    } vec_t;

    logic        clk;
    logic [1:0]  rst_v, req_v, we_v, inj_v;
    logic [31:0] add_v [2];
    logic [31:0] wdata_v [2];
    logic [3:0]  be_v [2];
    logic [1:0]  gnt_w, rv_w, err_w, oerr_w, busy_w;
    logic [31:0] rdata_w [2];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [c_DEPTH];

    dm_sba_mem_slave_if bus0 ();
    dm_sba_mem_slave_if bus1 ();

    assign bus0.slave_req_i   = req_v[0];
    assign bus0.slave_add_i   = add_v[0];
    assign bus0.slave_we_i    = we_v[0];
    assign bus0.slave_wdata_i = wdata_v[0];
    assign bus0.slave_be_i    = be_v[0];
    assign bus1.slave_req_i   = req_v[1];
    assign bus1.slave_add_i   = add_v[1];
    assign bus1.slave_we_i    = we_v[1];
    assign bus1.slave_wdata_i = wdata_v[1];
    assign bus1.slave_be_i    = be_v[1];
    assign gnt_w   = {bus1.slave_gnt_o, bus0.slave_gnt_o};
    assign rv_w    = {bus1.slave_r_valid_o, bus0.slave_r_valid_o};
    assign err_w   = {bus1.slave_r_err_o, bus0.slave_r_err_o};
    assign oerr_w  = {bus1.slave_r_other_err_o, bus0.slave_r_other_err_o};
    assign rdata_w[0] = bus0.slave_r_rdata_o;
    assign rdata_w[1] = bus1.slave_r_rdata_o;

    dm_sba_mem_slave #(.DEPTH(c_DEPTH), .BASE_ADDR(c_BASE), .GNT_LATENCY(0), .RESP_LATENCY(1))
    dut0 (.clk_i(clk), .rst_i(rst_v[0]), .bus(bus0), .inject_err_i(inj_v[0]), .busy_o(busy_w[0]));

    dm_sba_mem_slave #(.DEPTH(c_DEPTH), .BASE_ADDR(c_BASE), .GNT_LATENCY(2), .RESP_LATENCY(3))
    dut1 (.clk_i(clk), .rst_i(rst_v[1]), .bus(bus1), .inject_err_i(inj_v[1]), .busy_o(busy_w[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Contiguity by arithmetic: strip trailing zeros, remainder must be 2^k-1.
    function automatic logic be_contig(input logic [3:0] be);
        int v;
        v = int'(be);
        if (v == 0) return 1'b0;
        while ((v % 2) == 0) v = v / 2;
        return ((v & (v + 1)) == 0);
    endfunction

    task automatic ref_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                              input logic [3:0] be, input logic inj,
                              output logic e, output logic oe, output logic [31:0] rd);
        longint off;
        int     w;
        off = longint'(a) - longint'(c_BASE);
        e   = (off < 0) || (off >= longint'(c_DEPTH) * 4) || inj;
        oe  = !be_contig(be);
        rd  = 32'h0;
        if (!e && !oe) begin
            w = int'(off / 4);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                rd = ref_mem[w];
            end
        end
    endtask

    // One complete access; checks grant and response latency in cycles.
    task automatic access(input int d, input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input logic [3:0] be, input logic inj,
                          input int exp_gl, input int exp_rl,
                          output logic e, output logic oe, output logic [31:0] rd);
        int   n;
        int   m;
        logic got;
        @(posedge clk); #1;
        req_v[d] = 1'b1; add_v[d] = a; we_v[d] = we; wdata_v[d] = wd;
        be_v[d] = be; inj_v[d] = inj;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (gnt_w[d]) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        chk($sformatf("gnt_latency_dut%0d", d), n, exp_gl);
        @(posedge clk); #1;
        req_v[d] = 1'b0; inj_v[d] = 1'b0;
        m = 1; got = 1'b0;
        while (!got && m < 40) begin
            @(negedge clk);
            if (rv_w[d]) got = 1'b1;
            else begin @(posedge clk); #1; m++; end
        end
        chk($sformatf("resp_latency_dut%0d", d), m, exp_rl);
        e = err_w[d]; oe = oerr_w[d]; rd = rdata_w[d];
    endtask

    vec_t        tbl [21];
    logic        e, oe, me, moe;
    logic [31:0] rd, mrd, a, wd;
    logic        we, inj;
    logic [3:0]  be;

    initial begin
        tbl[0]  = '{32'h10,       1'b1, 32'hABCDABCD, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{32'h10,       1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'hABCDABCD};
        tbl[2]  = '{32'h14,       1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{32'h14,       1'b1, 32'h11223344, 4'h3, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{32'h14,       1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'hFFFF3344};
        tbl[5]  = '{32'h400,      1'b0, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{32'h18,       1'b1, 32'h55555555, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{32'h18,       1'b1, 32'h12345678, 4'h5, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[8]  = '{32'h18,       1'b1, 32'h12345678, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[9]  = '{32'h18,       1'b1, 32'h12345678, 4'h9, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[10] = '{32'h18,       1'b1, 32'h12345678, 4'hB, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[11] = '{32'h18,       1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'h55555555};
        tbl[12] = '{32'h18,       1'b0, 32'h0,        4'hF, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[13] = '{32'h3FC,      1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[14] = '{32'h3FE,      1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[15] = '{32'h404,      1'b1, 32'h0,        4'h5, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[16] = '{32'h10,       1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[17] = '{32'h14,       1'b0, 32'h0,        4'h6, 1'b0, 1'b0, 1'b0, 32'hFFFF3344};
        tbl[18] = '{32'h10,       1'b1, 32'h00BEEF00, 4'h6, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[19] = '{32'h10,       1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'hABBEEFCD};
        tbl[20] = '{32'hFFFFFFFC, 1'b1, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h0};

        rst_v = 2'b11; req_v = 2'b00; we_v = 2'b00; inj_v = 2'b00;
        for (int d = 0; d < 2; d++) begin
            add_v[d] = 32'h0; wdata_v[d] = 32'h0; be_v[d] = 4'hF;
        end
        repeat (3) @(posedge clk);
        #1 rst_v = 2'b00;

        // Reset values on both instances.
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_gnt%0d", d),   gnt_w[d],   1'b0);
            chk($sformatf("rst_rv%0d", d),    rv_w[d],    1'b0);
            chk($sformatf("rst_err%0d", d),   err_w[d],   1'b0);
            chk($sformatf("rst_oerr%0d", d),  oerr_w[d],  1'b0);
            chk($sformatf("rst_busy%0d", d),  busy_w[d],  1'b0);
            chk($sformatf("rst_rdata%0d", d), rdata_w[d], 32'h0);
        end

        // Fill the whole dut0 memory so every later read has a known value.
        for (int w = 0; w < c_DEPTH; w++) begin
            wd = $urandom;
            access(0, 32'(w * 4), 1'b1, wd, 4'hF, 1'b0, 0, 1, e, oe, rd);
            ref_access(32'(w * 4), 1'b1, wd, 4'hF, 1'b0, me, moe, mrd);
            chk("fill_err", e, me);
            chk("fill_oerr", oe, moe);
        end

        // Directed table on dut0.
        for (int i = 0; i < 21; i++) begin
            access(0, tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].be, tbl[i].inj, 0, 1, e, oe, rd);
            ref_access(tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].be, tbl[i].inj, me, moe, mrd);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
            chk($sformatf("tbl%0d_oerr", i), oe, tbl[i].oe);
            if (!tbl[i].we || tbl[i].e || tbl[i].oe)
                chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
        end

        // dut0: request held continuously; next grant only after the response.
        @(posedge clk); #1;
        req_v[0] = 1'b1; add_v[0] = 32'h14; we_v[0] = 1'b0; be_v[0] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_gnt_k%0d", k), gnt_w[0], (k == 0 || k == 2));
            chk($sformatf("b2b_rv_k%0d", k),  rv_w[0],  (k == 1 || k == 3));
            if (k == 1 || k == 3) chk($sformatf("b2b_rdata_k%0d", k), rdata_w[0], 32'hFFFF3344);
            @(posedge clk); #1;
            if (k == 2) req_v[0] = 1'b0;
        end

        // dut1: programmed latencies, cycle-exact gnt / r_valid / busy.
        @(posedge clk); #1;
        req_v[1] = 1'b1; add_v[1] = 32'h20; we_v[1] = 1'b1; wdata_v[1] = 32'hCAFEF00D; be_v[1] = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("lat_gnt_k%0d", k),  gnt_w[1],  (k == 2));
            chk($sformatf("lat_rv_k%0d", k),   rv_w[1],   (k == 5));
            chk($sformatf("lat_busy_k%0d", k), busy_w[1], (k >= 1 && k <= 5));
            @(posedge clk); #1;
            if (k == 2) req_v[1] = 1'b0;
        end
        access(1, 32'h20, 1'b0, 32'h0, 4'hF, 1'b0, 2, 3, e, oe, rd);
        chk("lat_read_rdata", rd, 32'hCAFEF00D);
        chk("lat_read_err", e, 1'b0);

        // dut1: request withdrawn before grant -> no access at all.
        @(posedge clk); #1;
        req_v[1] = 1'b1; add_v[1] = 32'h20; we_v[1] = 1'b1; wdata_v[1] = 32'h0BADBEEF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("drop_gnt_k%0d", k), gnt_w[1], 1'b0);
            chk($sformatf("drop_rv_k%0d", k),  rv_w[1],  1'b0);
            if (k >= 2) chk($sformatf("drop_busy_k%0d", k), busy_w[1], 1'b0);
            @(posedge clk); #1;
            req_v[1] = 1'b0;
        end
        access(1, 32'h20, 1'b0, 32'h0, 4'hF, 1'b0, 2, 3, e, oe, rd);
        chk("drop_read_rdata", rd, 32'hCAFEF00D);

        // dut1: fault injection on a valid read.
        access(1, 32'h20, 1'b0, 32'h0, 4'hF, 1'b1, 2, 3, e, oe, rd);
        chk("inj_err", e, 1'b1);
        chk("inj_rdata", rd, 32'h0);

        // dut1: reset during RESP_WAIT drops the response, keeps the write.
        @(posedge clk); #1;
        req_v[1] = 1'b1; add_v[1] = 32'h24; we_v[1] = 1'b1; wdata_v[1] = 32'h600DF00D; be_v[1] = 4'hF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 2) chk("rstseq_gnt", gnt_w[1], 1'b1);
            if (k >= 3) chk($sformatf("rstseq_no_rv_k%0d", k), rv_w[1], 1'b0);
            if (k >= 4) chk($sformatf("rstseq_busy_k%0d", k), busy_w[1], 1'b0);
            @(posedge clk); #1;
            if (k == 2) req_v[1] = 1'b0;
            rst_v[1] = (k == 2);
        end
        access(1, 32'h24, 1'b0, 32'h0, 4'hF, 1'b0, 2, 3, e, oe, rd);
        chk("rstseq_read_rdata", rd, 32'h600DF00D);
        chk("rstseq_read_err", e, 1'b0);

        // Randomized accesses on dut0 against the model.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                8:       a = 32'($urandom_range(1024, 4095));
                9:       a = $urandom;
                default: a = 32'($urandom_range(0, 1023));
            endcase
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            be  = 4'($urandom_range(0, 15));
            inj = ($urandom_range(0, 9) == 0);
            access(0, a, we, wd, be, inj, 0, 1, e, oe, rd);
            ref_access(a, we, wd, be, inj, me, moe, mrd);
            chk($sformatf("rnd%0d_err", i), e, me);
            chk($sformatf("rnd%0d_oerr", i), oe, moe);
            if (!we || me || moe) chk($sformatf("rnd%0d_rdata", i), rd, mrd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
